// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and types for the multdiv_ctrl unit.
package multdiv_pkg;

   localparam int ITERS = 32;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MUL_RUN   = 3'd1;
   localparam logic [2:0] S_DIV_ABS_A = 3'd2;
   localparam logic [2:0] S_DIV_ABS_B = 3'd3;
   localparam logic [2:0] S_DIV_RUN   = 3'd4;
   localparam logic [2:0] S_DIV_NEGQ  = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'b00,
      BOOTH_ADD = 2'b01,
      BOOTH_SUB = 2'b10
   } booth_t;

   typedef enum logic [2:0] {
      SEL_BOOTH,
      SEL_NEG_A,
      SEL_NEG_B,
      SEL_DIV_SUB,
      SEL_NEG_Q
   } add_sel_t;

   // pair is {P[0], q_-1}; 00 and 11 both mean no add
   function automatic booth_t booth_decode(input logic [1:0] pair);
      case (pair)
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - operand/control/result bundle between execute stage and multdiv_ctrl.
interface multdiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups rippling between groups.
module cla_adder (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout,
   output logic        o_ovf
);
   logic [31:0] w_g;
   logic [31:0] w_p;
   logic [32:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_c    = '0;
      w_c[0] = i_cin;
      for (int k = 0; k < 8; k++) begin
         w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
         w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      end
   end

   assign o_sum  = w_p ^ w_c[31:0];
   assign o_cout = w_c[32];
   assign o_ovf  = w_c[32] ^ w_c[31];
endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multdiv FSM and iteration counter driving the shared adder controls.
// Divide states exist only when MULTDIV_DIV_EN is defined.
module multdiv_seq
   import multdiv_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_mult,
   input  logic       i_div,
   input  logic [1:0] i_pair,
   output logic [2:0] o_state,
   output add_sel_t   o_sel,
   output logic       o_inv,
   output logic       o_cin,
   output logic       o_add,
   output logic       o_last,
   output logic       o_start_mul,
   output logic       o_start_div,
   output logic       o_busy,
   output logic       o_rdy
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_carry;
   logic             w_run;
   logic             w_cnt_end;
   booth_t           w_op;

   assign w_op        = booth_decode(i_pair);
   assign w_run       = (r_state == S_MUL_RUN) || (r_state == S_DIV_RUN);
   assign w_cnt_end   = (r_cnt == LAST_CNT);
   assign o_last      = w_run && w_cnt_end;
   assign o_start_mul = (r_state == S_IDLE) && i_mult;
   assign o_state     = r_state;
   assign o_busy      = (r_state != S_IDLE);
   assign o_rdy       = (r_state == S_DONE);

`ifdef MULTDIV_DIV_EN
   assign o_start_div = (r_state == S_IDLE) && i_div && !i_mult;
`else
   logic w_unused_div;
   assign w_unused_div = i_div;
   assign o_start_div  = 1'b0;
`endif

   // bitwise increment so the shared adder stays the only arithmetic unit
   always_comb begin
      w_carry   = 1'b1;
      w_cnt_inc = '0;
      for (int i = 0; i < CNT_W; i++) begin
         w_cnt_inc[i] = r_cnt[i] ^ w_carry;
         w_carry      = w_carry & r_cnt[i];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (o_start_mul)      w_state_nxt = S_MUL_RUN;
            else if (o_start_div) w_state_nxt = S_DIV_ABS_A;
         end
         S_MUL_RUN:   if (w_cnt_end) w_state_nxt = S_DONE;
`ifdef MULTDIV_DIV_EN
         S_DIV_ABS_A: w_state_nxt = S_DIV_ABS_B;
         S_DIV_ABS_B: w_state_nxt = S_DIV_RUN;
         S_DIV_RUN:   if (w_cnt_end) w_state_nxt = S_DIV_NEGQ;
         S_DIV_NEGQ:  w_state_nxt = S_DONE;
`endif
         S_DONE:      w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_sel = SEL_BOOTH;
      o_inv = 1'b0;
      o_cin = 1'b0;
      o_add = 1'b0;
      case (r_state)
         S_MUL_RUN: begin
            o_add = (w_op != BOOTH_NOP);
            o_inv = (w_op == BOOTH_SUB);
            o_cin = (w_op == BOOTH_SUB);
         end
`ifdef MULTDIV_DIV_EN
         S_DIV_ABS_A: begin o_sel = SEL_NEG_A;   o_inv = 1'b1; o_cin = 1'b1; end
         S_DIV_ABS_B: begin o_sel = SEL_NEG_B;   o_inv = 1'b1; o_cin = 1'b1; end
         S_DIV_RUN:   begin o_sel = SEL_DIV_SUB; o_inv = 1'b1; o_cin = 1'b1; end
         S_DIV_NEGQ:  begin o_sel = SEL_NEG_Q;   o_inv = 1'b1; o_cin = 1'b1; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (w_run && !w_cnt_end) ? w_cnt_inc : '0;
      end
   end
endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - multi-cycle signed Booth multiplier sharing one cla_adder over 32 iterations.
// Signed restoring divide is added when MULTDIV_DIV_EN is defined.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic          clock,
   input  logic          reset,
   multdiv_ctrl_if.slave bus
);
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_p;
   logic               r_q;
   logic [WIDTH-1:0]   r_result;
   logic               r_exc;

   logic [2:0]         w_state;
   add_sel_t           w_sel;
   logic               w_inv, w_cin, w_add, w_last;
   logic               w_start_mul, w_start_div, w_busy, w_rdy;
   logic [WIDTH-1:0]   w_a, w_b, w_b_adj, w_sum, w_sum_hi;
   logic               w_cout, w_ovf, w_shin;
   logic [2*WIDTH-1:0] w_p_mul;

   multdiv_seq #(.CNT_W(CNT_W)) u_seq (
      .clock       (clock),
      .reset       (reset),
      .i_mult      (bus.ctrl_MULT),
      .i_div       (bus.ctrl_DIV),
      .i_pair      ({r_p[0], r_q}),
      .o_state     (w_state),
      .o_sel       (w_sel),
      .o_inv       (w_inv),
      .o_cin       (w_cin),
      .o_add       (w_add),
      .o_last      (w_last),
      .o_start_mul (w_start_mul),
      .o_start_div (w_start_div),
      .o_busy      (w_busy),
      .o_rdy       (w_rdy)
   );

   // In division r_p holds {remainder, quotient}; a shifted-in remainder is the trial minuend
   always_comb begin
      w_a = r_p[2*WIDTH-1:WIDTH];
      w_b = r_a;
      case (w_sel)
         SEL_NEG_A:   begin w_a = '0; w_b = r_a; end
         SEL_NEG_B:   begin w_a = '0; w_b = r_b; end
         SEL_DIV_SUB: begin w_a = {r_p[2*WIDTH-2:WIDTH], r_p[WIDTH-1]}; w_b = r_b; end
         SEL_NEG_Q:   begin w_a = '0; w_b = r_p[WIDTH-1:0]; end
         default: ;
      endcase
   end

   assign w_b_adj = w_inv ? ~w_b : w_b;

   cla_adder u_add (
      .i_a    (w_a),
      .i_b    (w_b_adj),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   // sum[31]^ovf is the true sign of the 33-bit sum, keeping the shift exact at the extremes
   assign w_sum_hi = w_add ? w_sum : r_p[2*WIDTH-1:WIDTH];
   assign w_shin   = w_add ? (w_sum[WIDTH-1] ^ w_ovf) : r_p[2*WIDTH-1];
   assign w_p_mul  = {w_shin, w_sum_hi, r_p[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
   logic r_neg, r_div0, r_dovf;
`else
   logic w_unused_cout;
   assign w_unused_cout = w_cout;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_p      <= '0;
         r_q      <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
`ifdef MULTDIV_DIV_EN
         r_neg    <= 1'b0;
         r_div0   <= 1'b0;
         r_dovf   <= 1'b0;
`endif
      end else begin
         case (w_state)
            S_IDLE: begin
               if (w_start_mul) begin
                  r_a <= bus.data_operandA;
                  r_b <= bus.data_operandB;
                  r_p <= {{WIDTH{1'b0}}, bus.data_operandB};
                  r_q <= 1'b0;
               end
`ifdef MULTDIV_DIV_EN
               else if (w_start_div) begin
                  r_a    <= bus.data_operandA;
                  r_b    <= bus.data_operandB;
                  r_p    <= '0;
                  r_neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                  r_div0 <= (bus.data_operandB == '0);
                  r_dovf <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.data_operandB == {WIDTH{1'b1}});
               end
`endif
            end
            S_MUL_RUN: begin
               r_p <= w_p_mul;
               r_q <= r_p[0];
               if (w_last) begin
                  r_result <= w_p_mul[WIDTH-1:0];
                  r_exc    <= !((&w_p_mul[2*WIDTH-1:WIDTH-1]) || !(|w_p_mul[2*WIDTH-1:WIDTH-1]));
               end
            end
`ifdef MULTDIV_DIV_EN
            S_DIV_ABS_A: r_p <= {{WIDTH{1'b0}}, (r_a[WIDTH-1] ? w_sum : r_a)};
            S_DIV_ABS_B: if (r_b[WIDTH-1]) r_b <= w_sum;
            S_DIV_RUN:   r_p <= {(w_cout ? w_sum : w_a), r_p[WIDTH-2:0], w_cout};
            S_DIV_NEGQ: begin
               r_result <= r_div0 ? '0 : (r_neg ? w_sum : r_p[WIDTH-1:0]);
               r_exc    <= r_div0 || r_dovf;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.data_result    = r_result;
   assign bus.data_exception = r_exc;
   assign bus.data_resultRDY = w_rdy;
   assign bus.busy           = w_busy;
endmodule
